instruction_memory_loader: RTL and testbench
============================================

Name: instruction_memory_loader

Overview:
Writer side of the instruction memory. Accepts a byte stream from an external host or boot source and assembles it into 32-bit instruction words. Writes each word into the instruction memory array at consecutive byte addresses (BASE_ADDR, +4, +8, ...), matching the word-per-4-byte addressing used on the fetch side. Holds the CPU in reset while a load is in progress.

Parameters:
ADDR_WIDTH, 32, width of mem_addr; matches instruction_address.
BASE_ADDR, 0, byte address of the first word written.
MAX_WORDS, 32, largest legal word_count; equals instruction memory depth.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous, active-low reset
start  input  1  one-cycle pulse; begins a load when IDLE
word_count  input  8  number of 32-bit words to load; sampled on accepted start
byte_valid  input  1  byte_data valid
byte_data  input  8  stream byte, most significant byte of each word first
byte_ready  output  1  loader can accept a byte this cycle
mem_we  output  1  instruction memory write enable, one cycle per word
mem_addr  output  ADDR_WIDTH  byte address of the word being written
mem_wdata  output  32  assembled instruction word
busy  output  1  load in progress
done  output  1  one-cycle pulse when a load completes
error  output  1  sticky error flag
cpu_hold  output  1  holds the processor in reset; equals busy

Behaviour:
- The design has one clock. Reset is synchronous and active-low: with reset_n=0 at a rising edge, state goes to IDLE and every output goes to 0 (byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_hold). The byte counter and word counter also clear.
- States: IDLE, COLLECT, WRITE, CHECK (only with the optional feature), DONE.
- IDLE:
  - byte_ready=0.
  - On start=1 with 1 <= word_count <= MAX_WORDS: latch word_count into remaining, set addr=BASE_ADDR, clear error, set busy=cpu_hold=1, go to COLLECT.
  - On start=1 with word_count=0 or word_count>MAX_WORDS: set error=1, stay in IDLE, busy stays 0, no done pulse.
- COLLECT:
  - byte_ready=1.
  - A byte transfers when byte_valid && byte_ready. Each transfer does shreg <= {shreg[23:0], byte_data} and increments the byte index (0..3).
  - On the 4th transfer, go to WRITE.
  - If byte_valid is low, the loader waits indefinitely; there is no timeout.
- WRITE (exactly 1 cycle):
  - mem_we=1, mem_addr=addr, mem_wdata=shreg, byte_ready=0.
  - Next: addr += 4, remaining -= 1, byte index clears.
  - If remaining was 1, go to CHECK (with feature) or DONE; otherwise go to COLLECT.
- DONE (1 cycle): done=1. On the next cycle busy and cpu_hold fall to 0 and the state returns to IDLE.
- Throughput: with byte_valid held high, each word takes 5 cycles (4 accept + 1 write). An N-word load runs from the start edge to the done pulse in 5N+1 cycles without the feature.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- start is ignored while busy=1.
- Reset mid-load aborts immediately. Words already written stay in memory; a partially assembled word is discarded and never written.
- Address arithmetic is modulo 2^ADDR_WIDTH. Wrap cannot occur for legal word_count with default parameters.

Optional Feature:
Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit sum (modulo 256) accumulates every data byte and clears on accepted start.
  - After the last WRITE, the loader enters CHECK with byte_ready=1 and accepts exactly one checksum byte.
  - If (sum + checksum byte) mod 256 != 0, it sets error=1.
  - It then goes to DONE; done pulses regardless of the result.
- Undefined: no CHECK state and no sum register. WRITE of the last word goes directly to DONE.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, COLLECT, WRITE, CHECK, DONE} as 3-bit localparams;
  - WORD_BYTES=4;
  - INSTR_WIDTH=32.
- One sub-module is natural: word_assembler, containing the shift register plus byte index, with a word_ready output. The FSM stays in the top module.

Test Plan:
- Reset with reset_n=0 for 2 cycles, then release. Required: all outputs 0 and state IDLE.
- start with word_count=2, then bytes 01 23 45 67 89 AB CD EF with byte_valid held high. Required: mem_we at cycles 5 and 10 after start, writing 0x01234567@0x0 and 0x89ABCDEF@0x4; done pulses at cycle 11; cpu_hold high throughout.
- Repeat the previous scenario with byte_valid toggling 1/0 each cycle. Required: same writes and data, with write pulses spaced to match accepted bytes.
- start with word_count=0, then separately with word_count=33. Required: error=1, busy=0, no mem_we, no done. A following valid start clears error.
- Assert reset_n=0 after 6 bytes of a 2-word load. Required: only word 0 is written; outputs are 0 after reset; a fresh load then succeeds.
- With LOADER_CHECKSUM_EN, load 1 word 01 02 03 04, then checksum byte F6. Required: error=0. Repeat with checksum byte F7. Required: error=1 and done still pulses.

Source files
------------

// File: rtl/instruction_memory_loader_pkg.sv
// Shared definitions for the instruction memory loader.
// Optional checksum stage is enabled by defining LOADER_CHECKSUM_EN.
package instruction_memory_loader_pkg;

  localparam int unsigned WordBytes  = 4;
  localparam int unsigned InstrWidth = 32;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCollect = 3'd1,
    StWrite   = 3'd2,
    StCheck   = 3'd3,
    StDone    = 3'd4
  } state_e;

endpackage

// File: rtl/instruction_memory_loader_word_assembler.sv
// Shifts stream bytes (MSB first) into a 32-bit word and flags the byte that completes it.
module instruction_memory_loader_word_assembler
  import instruction_memory_loader_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic [InstrWidth-1:0] word_o,
  output logic                  word_ready_o
);

  localparam int unsigned IdxWidth = $clog2(WordBytes);

  logic [InstrWidth-1:0] shreg_q;
  logic [IdxWidth-1:0]   idx_q;

  // Shift register and byte index; clear only rewinds the index, the word is overwritten anyway
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (clear_i) begin
      idx_q   <= '0;
    end else if (byte_valid_i) begin
      shreg_q <= {shreg_q[InstrWidth-9:0], byte_i};
      idx_q   <= idx_q + 1'b1;
    end
  end

  // Word completes on the transfer of its last byte
  always_comb begin
    word_o       = shreg_q;
    word_ready_o = byte_valid_i && (idx_q == IdxWidth'(WordBytes - 1));
  end

endmodule

// File: rtl/instruction_memory_loader.sv
// Assembles a host byte stream into instruction words and writes them to instruction memory
// at BaseAddr, +4, +8, ... while holding the CPU in reset.
// Define LOADER_CHECKSUM_EN to require a trailing two's-complement checksum byte.
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int unsigned           AddrWidth = 32,
  parameter logic [AddrWidth-1:0]  BaseAddr  = '0,
  parameter int unsigned           MaxWords  = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            word_count,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [AddrWidth-1:0]  mem_addr,
  output logic [InstrWidth-1:0] mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  state_e state_q, state_d;

  logic [AddrWidth-1:0]  addr_q;
  logic [AddrWidth-1:0]  mem_addr_q;
  logic [InstrWidth-1:0] mem_wdata_q;
  logic [7:0]            remaining_q;
  logic                  error_q;

  logic                  xfer;
  logic                  start_ok;
  logic                  start_bad;
  logic                  word_ready;
  logic [InstrWidth-1:0] word;

  assign xfer      = byte_valid && byte_ready;
  assign start_ok  = start && (state_q == StIdle) && (word_count != 8'd0) &&
                     (32'(word_count) <= MaxWords);
  assign start_bad = start && (state_q == StIdle) && !start_ok;

  instruction_memory_loader_word_assembler u_word_assembler (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .clear_i      (start_ok || (state_q == StWrite)),
    .byte_valid_i (xfer && (state_q == StCollect)),
    .byte_i       (byte_data),
    .word_o       (word),
    .word_ready_o (word_ready)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_chk;
  assign sum_chk = sum_q + byte_data;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start_ok) state_d = StCollect;
      StCollect: if (word_ready) state_d = StWrite;
      StWrite: begin
        if (remaining_q == 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StCollect;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck:   if (xfer) state_d = StDone;
`endif
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs; address/data show the live word during WRITE and hold the last one otherwise
  always_comb begin
    byte_ready = (state_q == StCollect) || (state_q == StCheck);
    mem_we     = (state_q == StWrite);
    mem_addr   = mem_we ? addr_q : mem_addr_q;
    mem_wdata  = mem_we ? word : mem_wdata_q;
    busy       = (state_q != StIdle);
    done       = (state_q == StDone);
    error      = error_q;
    cpu_hold   = busy;
  end

  // Load bookkeeping: address, word countdown, held write outputs, sticky error
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      if (start_ok) begin
        remaining_q <= word_count;
        addr_q      <= BaseAddr;
        error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_q       <= '0;
`endif
      end else if (start_bad) begin
        error_q <= 1'b1;
      end
      if (state_q == StWrite) begin
        addr_q      <= addr_q + AddrWidth'(WordBytes);
        remaining_q <= remaining_q - 8'd1;
        mem_addr_q  <= addr_q;
        mem_wdata_q <= word;
      end
`ifdef LOADER_CHECKSUM_EN
      if ((state_q == StCollect) && xfer) begin
        sum_q <= sum_chk;
      end
      if ((state_q == StCheck) && xfer && (sum_chk != 8'd0)) begin
        error_q <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader; follows LOADER_CHECKSUM_EN if defined.
module tb_instruction_memory_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam int ChkBytes = 1;
`else
  localparam int ChkBytes = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  instruction_memory_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state; cycle numbers are relative to the start edge (first cycle after it is 1)
  bit          mon_on = 1'b0;
  int          start_c;
  int          we_n, done_n, done_c, hold_bad;
  int          we_c [8];
  logic [31:0] we_a [8];
  logic [31:0] we_d [8];
  logic        busy1, err1;

  always @(negedge clk) begin
    if (mon_on) begin
      if (mem_we) begin
        if (we_n < 8) begin
          we_c[we_n] = cyc - start_c + 1;
          we_a[we_n] = mem_addr;
          we_d[we_n] = mem_wdata;
        end
        we_n++;
      end
      if (done) begin
        done_n++;
        done_c = cyc - start_c + 1;
      end
      if (cpu_hold !== busy) hold_bad++;
      if (cyc - start_c + 1 == 1) begin
        busy1 = busy;
        err1  = error;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    we_n = 0; done_n = 0; done_c = -1; hold_bad = 0; busy1 = 1'bx; err1 = 1'bx;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 0);
    check({tag, "_mem_we"},     32'(mem_we),     0);
    check({tag, "_mem_addr"},   mem_addr,        0);
    check({tag, "_mem_wdata"},  mem_wdata,       0);
    check({tag, "_busy"},       32'(busy),       0);
    check({tag, "_done"},       32'(done),       0);
    check({tag, "_error"},      32'(error),      0);
    check({tag, "_cpu_hold"},   32'(cpu_hold),   0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle after the start edge
  task automatic do_start(input logic [7:0] wc);
    word_count = wc;
    start      = 1'b1;
    @(posedge clk); #1;
    start_c = cyc;
    start   = 1'b0;
  endtask

  // Offers bytes (MSB of the 72-bit vector first) until n are accepted
  task automatic drive(input logic [71:0] bytes, input int n, input bit tog_mode);
    int k = 0;
    int t = 0;
    bit tog = 1'b1;
    bit acc;
    while (k < n && t < 60) begin
      byte_valid = tog_mode ? tog : 1'b1;
      byte_data  = bytes[71 - 8*k -: 8];
      @(negedge clk);
      acc = byte_valid && byte_ready;
      @(posedge clk); #1;
      if (acc) k++;
      tog = ~tog;
      t++;
    end
    byte_valid = 1'b0;
    if (k < n) check("byte_budget", 32'(k), 32'(n));
  endtask

  typedef struct {
    logic [7:0]  wc;
    bit          tog;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  chk;
    bit          chk_err;
    int          we0;
    int          we1;
    int          dn;
  } load_vec_t;

  load_vec_t   vecs [5];
  logic [7:0]  bad_wc [3];

  task automatic run_load(input load_vec_t v, input int idx);
    logic [71:0] bytes;
    string       p;
    p = $sformatf("v%0d", idx);
    bytes = (v.wc == 8'd1) ? {v.w0, v.chk, 32'h0} : {v.w0, v.w1, v.chk};
    mon_clear();
    mon_on = 1'b1;
    do_start(v.wc);
    drive(bytes, 4 * int'(v.wc) + ChkBytes, v.tog);
    for (int i = 0; i < 40 && done_n == 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b0;
    check({p, "_busy_c1"},  32'(busy1), 1);
    check({p, "_err_c1"},   32'(err1), 0);
    check({p, "_we_count"}, 32'(we_n), 32'(v.wc));
    check({p, "_we0_cyc"},  32'(we_c[0]), 32'(v.we0));
    check({p, "_we0_addr"}, we_a[0], 32'h0);
    check({p, "_we0_data"}, we_d[0], v.w0);
    if (v.wc == 8'd2) begin
      check({p, "_we1_cyc"},  32'(we_c[1]), 32'(v.we1));
      check({p, "_we1_addr"}, we_a[1], 32'h4);
      check({p, "_we1_data"}, we_d[1], v.w1);
    end
    check({p, "_done_count"}, 32'(done_n), 1);
    check({p, "_done_cyc"},   32'(done_c), 32'(v.dn + ChkBytes));
    check({p, "_hold_eq_busy"}, 32'(hold_bad), 0);
    check({p, "_busy_end"},   32'(busy), 0);
    check({p, "_error_end"},  32'(error), (ChkBytes != 0) ? 32'(v.chk_err) : 32'd0);
    check({p, "_addr_hold"},  mem_addr, 32'(4 * (int'(v.wc) - 1)));
    check({p, "_data_hold"},  mem_wdata, (v.wc == 8'd2) ? v.w1 : v.w0);
  endtask

  initial begin
    // Checksum bytes: 0x40 balances 01..EF, 0xC8 balances DEADBEEF, 0xF6 balances 01020304
    vecs[0] = '{8'd2, 1'b0, 32'h01234567, 32'h89ABCDEF, 8'h40, 1'b0, 5, 10, 11};
    vecs[1] = '{8'd2, 1'b1, 32'h01234567, 32'h89ABCDEF, 8'h40, 1'b0, 8, 16, 17};
    vecs[2] = '{8'd1, 1'b0, 32'hDEADBEEF, 32'h0,        8'hC8, 1'b0, 5, 0, 6};
    vecs[3] = '{8'd1, 1'b0, 32'h01020304, 32'h0,        8'hF6, 1'b0, 5, 0, 6};
    vecs[4] = '{8'd1, 1'b0, 32'h01020304, 32'h0,        8'hF7, 1'b1, 5, 0, 6};
    bad_wc[0] = 8'd0;
    bad_wc[1] = 8'd33;
    bad_wc[2] = 8'd255;

    reset_n = 1'b0; start = 1'b0; word_count = 8'd0; byte_valid = 1'b0; byte_data = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_load(vecs[0], 0);
    run_load(vecs[1], 1);

    // Illegal word counts: error set, nothing written, no done
    for (int i = 0; i < 3; i++) begin
      mon_clear();
      mon_on = 1'b1;
      do_start(bad_wc[i]);
      repeat (4) @(posedge clk);
      #1;
      mon_on = 1'b0;
      check($sformatf("bad%0d_error", i), 32'(error), 1);
      check($sformatf("bad%0d_busy", i),  32'(busy), 0);
      check($sformatf("bad%0d_we", i),    32'(we_n), 0);
      check($sformatf("bad%0d_done", i),  32'(done_n), 0);
    end

    // Legal start afterwards clears the error (checked at cycle 1 inside run_load)
    run_load(vecs[2], 2);

    // Reset after 6 bytes of a 2-word load: only word 0 reaches memory
    mon_clear();
    mon_on = 1'b1;
    do_start(8'd2);
    drive({32'h01234567, 32'h89ABCDEF, 8'h00}, 6, 1'b0);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mon_on = 1'b0;
    check_zero("midrst");
    check("midrst_we_count", 32'(we_n), 1);
    check("midrst_we0_data", we_d[0], 32'h01234567);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_load(vecs[3], 3);
    run_load(vecs[4], 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
